// File: rtl/mole_pkg.sv
// Shared game-control definitions: FSM states, hole count and LFSR constants.
// The display block reuses NUM_HOLES and HOLE_W.
package mole_pkg;

  localparam int unsigned NUM_HOLES = 5;
  localparam int unsigned HOLE_W    = 3;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned LFSR_W    = 8;
  localparam int unsigned TIMER_W   = 16;

  // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_UP,
    ST_GAP,
    ST_DONE
  } state_t;

  // Hole after h in the 1..NUM_HOLES ring
  function automatic logic [HOLE_W-1:0] next_hole(input logic [HOLE_W-1:0] h);
    return (h >= HOLE_W'(NUM_HOLES)) ? HOLE_W'(1) : h + HOLE_W'(1);
  endfunction

  // Candidate hole derived from the LFSR state
  function automatic logic [HOLE_W-1:0] lfsr_hole(input logic [LFSR_W-1:0] v);
    return HOLE_W'(v % LFSR_W'(NUM_HOLES)) + HOLE_W'(1);
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Player/display-side signal bundle of the mole scheduler.
interface mole_scheduler_if;
  import mole_pkg::*;

  logic                 start;
  logic [NUM_HOLES-1:0] btn;
  logic [HOLE_W-1:0]    oval_select;
  logic                 mole_visible;
  logic                 hit;
  logic [CNT_W-1:0]     score;
  logic [CNT_W-1:0]     misses;
  logic                 game_over;

  modport master (
    output start, btn,
    input  oval_select, mole_visible, hit, score, misses, game_over
  );

  modport slave (
    input  start, btn,
    output oval_select, mole_visible, hit, score, misses, game_over
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector, one lane per bit.
module btn_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: picks a hole per round, times the mole,
// scores hits and timeouts until the configured number of rounds is played.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned MOLE_TICKS = 800,
  parameter int unsigned GAP_TICKS  = 300,
  parameter int unsigned ROUNDS     = 20
) (
  input logic              clk,
  input logic              reset,
  mole_scheduler_if.slave  bus
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [LFSR_W-1:0]    lfsr_q;
  logic [HOLE_W-1:0]    oval_q, oval_d;
  logic [CNT_W-1:0]     score_q, score_d;
  logic [CNT_W-1:0]     misses_q, misses_d;
  logic [CNT_W-1:0]     round_q, round_d;
  logic                 hit_q, hit_d;
  logic                 mole_visible_q;
  logic                 game_over_q;

  logic                 enter;
  logic                 tick;
  logic                 expire;
  logic                 start_rise;
  logic [NUM_HOLES-1:0] btn_rise;
  logic [NUM_HOLES-1:0] hole_mask;
  logic                 hole_hit;
  logic [HOLE_W-1:0]    cand;
  logic [HOLE_W-1:0]    pick;

  btn_sync_edge #(.W(NUM_HOLES)) u_btn_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.btn),
    .rise_c (btn_rise)
  );

  btn_sync_edge #(.W(1)) u_start_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.start),
    .rise_c (start_rise)
  );

  assign tick      = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign expire    = tick && (timer_q == '0);
  assign hole_mask = NUM_HOLES'(1) << (oval_q - HOLE_W'(1));
  assign hole_hit  = |(hole_mask & btn_rise);

  // Never show the same hole twice in a row
  assign cand = lfsr_hole(lfsr_q);
  assign pick = (cand == oval_q) ? next_hole(cand) : cand;

  // Next-state and datapath updates; a start edge outside IDLE/DONE aborts the round
  always_comb begin
    state_d  = state_q;
    oval_d   = oval_q;
    score_d  = score_q;
    misses_d = misses_q;
    round_d  = round_q;
    timer_d  = timer_q;
    hit_d    = 1'b0;
    enter    = 1'b0;

    if (tick && (timer_q != '0)) begin
      timer_d = timer_q - TIMER_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_GAP, ST_UP, ST_SPAWN: begin
        if (start_rise) begin
          state_d  = ST_SPAWN;
          score_d  = '0;
          misses_d = '0;
          round_d  = '0;
          enter    = 1'b1;
        end else begin
          case (state_q)
            ST_SPAWN: begin
              oval_d  = pick;
              timer_d = TIMER_W'(MOLE_TICKS - 1);
              state_d = ST_UP;
              enter   = 1'b1;
            end
            ST_UP: begin
              if (hole_hit || expire) begin
                if (hole_hit) begin
                  hit_d   = 1'b1;
                  score_d = (score_q == '1) ? score_q : score_q + CNT_W'(1);
                end else begin
                  misses_d = (misses_q == '1) ? misses_q : misses_q + CNT_W'(1);
                end
                round_d = round_q + CNT_W'(1);
                timer_d = TIMER_W'(GAP_TICKS - 1);
                state_d = ST_GAP;
                enter   = 1'b1;
              end
            end
            ST_GAP: begin
              if (expire) begin
                state_d = (round_q == CNT_W'(ROUNDS)) ? ST_DONE : ST_SPAWN;
                enter   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Fresh tick period on every state entry
    presc_d = (enter || tick) ? '0 : presc_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      timer_q        <= '0;
      lfsr_q         <= LFSR_SEED;
      oval_q         <= '0;
      score_q        <= '0;
      misses_q       <= '0;
      round_q        <= '0;
      hit_q          <= 1'b0;
      mole_visible_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      timer_q        <= timer_d;
      lfsr_q         <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      oval_q         <= oval_d;
      score_q        <= score_d;
      misses_q       <= misses_d;
      round_q        <= round_d;
      hit_q          <= hit_d;
      mole_visible_q <= (state_d == ST_UP);
      game_over_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.oval_select  = oval_q;
  assign bus.mole_visible = mole_visible_q;
  assign bus.hit          = hit_q;
  assign bus.score        = score_q;
  assign bus.misses       = misses_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed-plus-random bench for mole_scheduler with a round-level scoreboard.
module tb_mole_scheduler;
  import mole_pkg::*;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned MOLE_TICKS = 10;
  localparam int unsigned GAP_TICKS  = 3;
  localparam int unsigned ROUNDS     = 4;

  logic clk;
  logic reset;

  int checks     = 0;
  int errors     = 0;
  int exp_score  = 0;
  int exp_misses = 0;
  int prev_hole  = 0;

  mole_scheduler_if bus ();

  mole_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .MOLE_TICKS (MOLE_TICKS),
    .GAP_TICKS  (GAP_TICKS),
    .ROUNDS     (ROUNDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_oval"},   32'(bus.oval_select),  0);
    check({tag, "_mole"},   32'(bus.mole_visible), 0);
    check({tag, "_hit"},    32'(bus.hit),          0);
    check({tag, "_score"},  32'(bus.score),        0);
    check({tag, "_misses"}, 32'(bus.misses),       0);
    check({tag, "_over"},   32'(bus.game_over),    0);
  endtask

  // Bounded wait on mole_visible, sampled on falling edges
  task automatic wait_mv(input logic lvl, input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.mole_visible !== lvl && n < budget);
    check(tag, 32'(bus.mole_visible), 32'(lvl));
  endtask

  // mode 0: timely hit, 1: wrong button then timeout, 2: hit in the expire cycle, 3: idle timeout
  task automatic play_round(input int mode);
    int hole;
    int d;
    int cnt;
    int w;
    bit saw_hit;
    wait_mv(1'b1, 30, "mole_up");
    hole = int'(bus.oval_select);
    check("hole_range", 32'(hole >= 1 && hole <= 5), 1);
    if (prev_hole != 0) check("no_repeat", 32'(hole != prev_hole), 1);
    prev_hole = hole;
    if (mode == 0 || mode == 2) begin
      // Mole rose at edge E; button hits the pins just after edge E+d
      d = (mode == 2) ? 37 : int'($urandom_range(1, 30));
      repeat (d) @(posedge clk);
      #1 bus.btn = 5'(1 << (hole - 1));
      repeat (3) @(negedge clk);
      check("hit_early", 32'(bus.hit), 0);
      check("mole_before_hit", 32'(bus.mole_visible), 1);
      @(negedge clk);
      exp_score++;
      check("hit_pulse", 32'(bus.hit), 1);
      check("mole_drop_on_hit", 32'(bus.mole_visible), 0);
      @(posedge clk);
      #1 bus.btn = '0;
      @(negedge clk);
      check("hit_one_cycle", 32'(bus.hit), 0);
    end else begin
      cnt     = 1;
      saw_hit = 1'b0;
      w       = ((hole - 1 + int'($urandom_range(1, 4))) % 5) + 1;
      while (bus.mole_visible === 1'b1 && cnt < 60) begin
        if (mode == 1 && cnt == 5) bus.btn = 5'(1 << (w - 1));
        if (cnt == 12) bus.btn = '0;
        @(negedge clk);
        if (bus.hit === 1'b1) saw_hit = 1'b1;
        if (bus.mole_visible === 1'b1) cnt++;
      end
      exp_misses++;
      check("no_hit_on_miss", 32'(saw_hit), 0);
      check("up_time", 32'(cnt >= 39 && cnt <= 41), 1);
    end
    check("score", 32'(bus.score), 32'(exp_score));
    check("misses", 32'(bus.misses), 32'(exp_misses));
    check("oval_hold", 32'(bus.oval_select), 32'(hole));
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.btn   = '0;
    #3 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    repeat (100) @(negedge clk);
    check_all_zero("idle");

    // First game: hit, wrong button, simultaneous hit/expire, random last round
    repeat (int'($urandom_range(1, 7))) @(posedge clk);
    #1 bus.start = 1'b1;
    play_round(0);
    bus.start = 1'b0;
    play_round(1);
    play_round(2);
    play_round(int'($urandom_range(0, 1)) * 3);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.game_over !== 1'b1 && n < 30);
    check("game_over", 32'(bus.game_over), 1);
    check("done_mole", 32'(bus.mole_visible), 0);
    check("done_score", 32'(bus.score), 32'(exp_score));
    check("done_misses", 32'(bus.misses), 32'(exp_misses));
    check("done_oval", 32'(bus.oval_select), 32'(prev_hole));

    // Restart from DONE clears counters when SPAWN is entered
    @(posedge clk);
    #1 bus.start = 1'b1;
    repeat (4) @(negedge clk);
    check("restart_over", 32'(bus.game_over), 0);
    check("restart_score", 32'(bus.score), 0);
    check("restart_misses", 32'(bus.misses), 0);
    exp_score  = 0;
    exp_misses = 0;
    play_round(0);

    // Asynchronous reset while the mole is up
    wait_mv(1'b1, 30, "mole_up_pre_reset");
    repeat (int'($urandom_range(1, 20))) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_all_zero("async_reset");
    prev_hole  = 0;
    exp_score  = 0;
    exp_misses = 0;
    bus.start  = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_mole", 32'(bus.mole_visible), 0);
    check("post_reset_oval", 32'(bus.oval_select), 0);
    check("post_reset_over", 32'(bus.game_over), 0);

    @(posedge clk);
    #1 bus.start = 1'b1;
    play_round(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
